booth_dot_accumulator: RTL and testbench

Sequential accumulate stage directly downstream of the combinational `booth_multiplier`. It consumes the signed 8-bit products `Z` over a valid/ready handshake and sums a fixed-length group of `LEN` products with signed saturation. It then presents the dot-product result on a second valid/ready handshake. It turns the single-cycle 4x4 Booth multiplier into a small dot-product engine.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_dot_accumulator_sat_add.sv | 31 +++
 rtl/booth_dot_accumulator.sv | 99 +++++++++
 tb/tb_booth_dot_accumulator.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared constants, FSM state type and saturation-bound helpers for the
// Booth dot-product accumulator.
package booth_pkg;

  localparam int PROD_W_DEFAULT = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/booth_dot_accumulator_sat_add.sv
// Combinational ACC_W-bit signed saturating adder; b is sign-extended and
// overflow is read from the top two bits of an ACC_W+1-bit sum.
module sat_add
  import booth_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int PROD_W = PROD_W_DEFAULT
) (
  input  logic signed [ACC_W-1:0]  a,
  input  logic signed [PROD_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] MIN_VAL = ACC_W'(sat_min(ACC_W));

  logic [ACC_W:0] wide;

  assign wide = {a[ACC_W-1], a} + {{(ACC_W + 1 - PROD_W){b[PROD_W-1]}}, b};

  always_comb begin
    sum = wide[ACC_W-1:0];
    ovf = 1'b0;
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      ovf = 1'b1;
      sum = wide[ACC_W] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/booth_dot_accumulator.sv
// Sums groups of LEN signed products with saturation and presents each
// group result on a valid/ready output handshake.
module booth_dot_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEFAULT,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic                     out_ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic                     ovf_reg, ovf_next;
  logic signed [ACC_W-1:0]  sum;
  logic                     sum_ovf;

  sat_add #(
    .ACC_W (ACC_W),
    .PROD_W(PROD_W)
  ) u_sat_add (
    .a  (acc_reg),
    .b  (in_prod),
    .sum(sum),
    .ovf(sum_ovf)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    ovf_next   = ovf_reg;
    in_ready   = (state_reg == ACCUM);
    out_valid  = (state_reg == HOLD);

    if (clr) begin
      state_next = ACCUM;
      cnt_next   = '0;
      acc_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (in_valid) begin
            acc_next = sum;
            ovf_next = ovf_reg | sum_ovf;
            if (cnt_reg == LAST) begin
              state_next = HOLD;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_next = ACCUM;
            cnt_next   = '0;
            acc_next   = '0;
            ovf_next   = 1'b0;
          end
        end
        default: state_next = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ACCUM;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
    end
  end

  // The running partial sum is only exposed once the group is complete.
  assign out_acc = (state_reg == HOLD) ? acc_reg : '0;
  assign out_ovf = (state_reg == HOLD) ? ovf_reg : 1'b0;

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Directed, table-driven bench: 16-bit and 8-bit accumulators (LEN=4) plus a
// LEN=1 instance, all driven from the same input stimulus.
module tb_booth_dot_accumulator;

  logic clk = 1'b0;
  logic rst_n, clr, in_valid, out_ready;
  logic signed [7:0] in_prod;

  logic ir16, ov16, of16;
  logic signed [15:0] acc16;
  logic ir8, ov8, of8;
  logic signed [7:0] acc8;
  logic ir1, ov1, of1;
  logic signed [15:0] acc1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_dot_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir16),
    .in_prod(in_prod), .out_valid(ov16), .out_ready(out_ready),
    .out_acc(acc16), .out_ovf(of16)
  );

  booth_dot_accumulator #(.PROD_W(8), .ACC_W(8), .LEN(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir8),
    .in_prod(in_prod), .out_valid(ov8), .out_ready(out_ready),
    .out_acc(acc8), .out_ovf(of8)
  );

  booth_dot_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir1),
    .in_prod(in_prod), .out_valid(ov1), .out_ready(out_ready),
    .out_acc(acc1), .out_ovf(of1)
  );

  typedef struct {
    logic [3:0][7:0] p;
    bit              gap;
    int              hold;
    int              exp16;
    bit              ovf16;
    int              exp8;
    bit              ovf8;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_group(input vec_t v, input int idx);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_prod  = $signed(v.p[i]);
      tick();
      if (i == 2) check($sformatf("g%0d_no_early_valid", idx), int'(ov16), 0);
      if (v.gap && i < 3) begin
        in_valid = 1'b0;
        in_prod  = 8'sd99;
        tick();
      end
    end
    in_valid = 1'b0;
    check($sformatf("g%0d_valid16", idx), int'(ov16), 1);
    check($sformatf("g%0d_ready16", idx), int'(ir16), 0);
    check($sformatf("g%0d_acc16", idx), int'(acc16), v.exp16);
    check($sformatf("g%0d_ovf16", idx), int'(of16), int'(v.ovf16));
    check($sformatf("g%0d_valid8", idx), int'(ov8), 1);
    check($sformatf("g%0d_acc8", idx), int'(acc8), v.exp8);
    check($sformatf("g%0d_ovf8", idx), int'(of8), int'(v.ovf8));
    for (int h = 0; h < v.hold; h++) begin
      in_valid = 1'b1;
      in_prod  = 8'sd5;
      tick();
      check($sformatf("g%0d_bp_ready%0d", idx, h), int'(ir16), 0);
      check($sformatf("g%0d_bp_acc%0d", idx, h), int'(acc16), v.exp16);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("g%0d_release_valid", idx), int'(ov16), 0);
    check($sformatf("g%0d_release_ready", idx), int'(ir16), 1);
    check($sformatf("g%0d_release_acc", idx), int'(acc16), 0);
    $display("group %0d: acc16=%0d ovf16=%0b acc8=%0d ovf8=%0b",
             idx, v.exp16, v.ovf16, v.exp8, v.ovf8);
  endtask

  initial begin
    vecs[0] = '{p: {8'sd1, 8'sd64, -8'sd14, 8'sd15}, gap: 0, hold: 3,
                exp16: 66, ovf16: 0, exp8: 66, ovf8: 0};
    vecs[1] = '{p: {8'sd64, 8'sd64, 8'sd64, 8'sd64}, gap: 0, hold: 0,
                exp16: 256, ovf16: 0, exp8: 127, ovf8: 1};
    vecs[2] = '{p: {-8'sd56, -8'sd56, -8'sd56, -8'sd56}, gap: 0, hold: 0,
                exp16: -224, ovf16: 0, exp8: -128, ovf8: 1};
    vecs[3] = '{p: {8'sd63, -8'sd64, 8'sd64, -8'sd64}, gap: 1, hold: 0,
                exp16: -1, ovf16: 0, exp8: -1, ovf8: 0};
    vecs[4] = '{p: {-8'sd128, -8'sd128, 8'sd127, 8'sd127}, gap: 0, hold: 1,
                exp16: -2, ovf16: 0, exp8: -128, ovf8: 1};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_prod = 8'sd99; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(ir16), 1);
    check("rst_out_valid", int'(ov16), 0);
    check("rst_out_acc", int'(acc16), 0);
    check("rst_out_ovf", int'(of16), 0);
    $display("reset: in_ready=%0b out_valid=%0b out_acc=%0d", ir16, ov16, acc16);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();

    // LEN=1 goes straight to HOLD; clr then drops the pending result.
    in_valid = 1'b1;
    in_prod  = 8'sd15;
    tick();
    in_valid = 1'b0;
    check("len1_valid", int'(ov1), 1);
    check("len1_acc", int'(acc1), 15);
    check("len1_ready", int'(ir1), 0);
    check("len4_not_done", int'(ov16), 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("len1_clr_drop", int'(ov1), 0);
    check("len1_clr_acc", int'(acc1), 0);
    $display("len1: product 15 presented, then dropped by clr");

    for (int k = 0; k < 4; k++) run_group(vecs[k], k);

    // Mid-group clr: 10 and 20 accepted, 30 arrives with clr and is ignored.
    in_valid = 1'b1;
    in_prod  = 8'sd10;
    tick();
    in_prod  = 8'sd20;
    tick();
    in_prod  = 8'sd30;
    clr      = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_valid", int'(ov16), 0);
    check("clr_ready", int'(ir16), 1);
    $display("clr: partial group 10,20 discarded, 30 ignored");
    begin
      vec_t v;
      v = '{p: {8'sd1, 8'sd1, 8'sd1, 8'sd1}, gap: 0, hold: 0,
            exp16: 4, ovf16: 0, exp8: 4, ovf8: 0};
      run_group(v, 5);
    end

    run_group(vecs[4], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
